// File: rtl/pipe_pkg.sv
// Shared constants for the pipe_reg_chain register slice: depth bounds,
// default payload width and the saturating stall-counter helper.
package pipe_pkg;

  localparam int PIPE_DEPTH_MIN     = 1;
  localparam int PIPE_DEPTH_MAX     = 8;
  localparam int PIPE_WIDTH_DEFAULT = 32;
  localparam int STALL_CNT_W        = 32;

  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] value);
    return (value == STALL_CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: valid bit, payload register and the
// combinational ready that lets an empty stage absorb a bubble.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_dn_rdy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_rdy
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // An empty stage is always ready, so bubbles collapse under backpressure.
  assign o_rdy   = !r_valid || i_dn_rdy;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would let a payload race
  // through several stages in one clock.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_rdy) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_data <= i_up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with synchronous flush.
// Optional backpressure counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  if (DEPTH < PIPE_DEPTH_MIN || DEPTH > PIPE_DEPTH_MAX) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH out of range");
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;
    logic             w_dn_rdy;
    logic             w_valid;
    logic [WIDTH-1:0] w_data;
    logic             w_rdy;

    if (i == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = in_data;
    end else begin : g_body
      assign w_up_valid = g_stage[i-1].w_valid;
      assign w_up_data  = g_stage[i-1].w_data;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign w_dn_rdy = out_ready;
    end else begin : g_link
      assign w_dn_rdy = g_stage[i+1].w_rdy;
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .i_up_valid (w_up_valid),
      .i_up_data  (w_up_data),
      .i_dn_rdy   (w_dn_rdy),
      .o_valid    (w_valid),
      .o_data     (w_data),
      .o_rdy      (w_rdy)
    );
  end

  // Data offered during a flush is dropped, so refuse it at the handshake.
  assign in_ready  = g_stage[0].w_rdy && !clr;
  assign out_valid = g_stage[DEPTH-1].w_valid;
  assign out_data  = g_stage[DEPTH-1].w_data;

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Only reset clears the counter; a flush leaves the statistic intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
